id_ex_hazard_stage: RTL

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I pipeline. It captures decoded operands and control from ID and presents them to EX. Its ex_rs1/ex_rs2 feed the EX-stage forwarding unit directly. It detects load-use hazards that forwarding cannot resolve, stalls PC and IF/ID, inserts a bubble, and handles branch flush and a global memory hold.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/load_use_detect.sv | 27 ++
 rtl/id_ex_hazard_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32I core: ALU op encoding and ID/EX control bundle.
package pipe_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluSll   = 4'd2,
    AluSlt   = 4'd3,
    AluSltu  = 4'd4,
    AluXor   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluOr    = 4'd8,
    AluAnd   = 4'd9,
    AluLui   = 4'd10,
    AluPassB = 4'd11,
    AluRsv12 = 4'd12,
    AluRsv13 = 4'd13,
    AluRsv14 = 4'd14,
    AluRsv15 = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } id_ex_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // All-zero control: no writeback, no memory access, no branch.
  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    alu_op:     AluAdd
  };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  output logic       o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;

  // A load into x0 never produces a value, so it can never be a dependency.
  always_comb begin
    w_rs1_match = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    w_rs2_match = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    o_hazard    = i_ex_valid & i_ex_mem_read & (i_ex_rd != REG_X0) & i_id_valid &
                  (w_rs1_match | w_rs2_match);
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and memory hold.
module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic [3:0]       id_alu_op,
  input  logic             ex_flush,
  input  logic             mem_hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic [3:0]       ex_alu_op,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  id_ex_ctrl_t      r_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_hazard;
  logic             w_bubble;
  id_ex_ctrl_t      w_id_ctrl;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .o_hazard      (w_hazard)
  );

  // Stall is suppressed by a flush: the dependent instruction is being squashed anyway.
  assign stall_o  = w_hazard & ~ex_flush;
  assign w_bubble = ex_flush | w_hazard;

  // ID control with side-effecting bits masked when ID holds no real instruction.
  always_comb begin
    w_id_ctrl            = CTRL_BUBBLE;
    w_id_ctrl.reg_write  = id_reg_write & id_valid;
    w_id_ctrl.mem_read   = id_mem_read & id_valid;
    w_id_ctrl.mem_write  = id_mem_write & id_valid;
    w_id_ctrl.mem_to_reg = id_mem_to_reg;
    w_id_ctrl.alu_src    = id_alu_src;
    w_id_ctrl.branch     = id_branch & id_valid;
    w_id_ctrl.alu_op     = alu_op_e'(id_alu_op);
  end

  // Pipeline register: hold, bubble (zero indices avoid spurious forwarding) or capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= REG_X0;
      r_rs2      <= REG_X0;
      r_rd       <= REG_X0;
      r_ctrl     <= CTRL_BUBBLE;
    end else if (!mem_hold) begin
      if (w_bubble) begin
        r_valid    <= 1'b0;
        r_pc       <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_rs1      <= REG_X0;
        r_rs2      <= REG_X0;
        r_rd       <= REG_X0;
        r_ctrl     <= CTRL_BUBBLE;
      end else begin
        r_valid    <= id_valid;
        r_pc       <= id_pc;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_rd       <= id_rd;
        r_ctrl     <= w_id_ctrl;
      end
    end
  end

  // Saturating event counters; flush takes precedence over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!mem_hold) begin
      if (ex_flush) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_hazard) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_branch     = r_ctrl.branch;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

endmodule
